// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds FSM state encodings, PC defaults and the prefetch entry layout.
package if_pkg;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

  localparam logic [15:0] IF_RESET_PC = 16'h0000;
  localparam logic [15:0] IF_PC_STEP  = 16'd2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } if_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: imem req/ack, redirect, instr valid/ready.
// master = fetch unit side, slave = memory/datapath side.
interface instr_fetch_unit_if;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO: sync push/pop/flush, count out, async active-low reset.
// Head reads as zero while empty so idle outputs stay clean.
module if_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, one-outstanding imem reads, prefetch FIFO.
// Optional IF_MISALIGN_TRAP_EN adds a sticky misalign_err that halts fetch.
module instr_fetch_unit
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = IF_RESET_PC,
  parameter logic [15:0] PC_STEP  = IF_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic               misalign_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  if_state_e   state;
  if_state_e   state_n;
  logic [15:0] fetch_pc;
  logic [15:0] pc_n;
  logic        req_q;
  logic        req_n;
  logic [15:0] addr_q;
  logic [15:0] addr_n;
  logic        push;
  logic        flush;
  logic        pop;
  logic        redir;
  logic        ack;
  logic        room;
  logic [15:0] tgt;
  logic [15:0] pc_inc;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_next;
  logic        empty;
  logic        full;
  if_entry_t   wdata;
  if_entry_t   rdata;

  assign redir    = bus.redirect_valid;
  assign ack      = bus.mem_ack;
  assign pop      = ~empty & bus.instr_ready;
  assign pc_inc   = fetch_pc + PC_STEP;
  assign cnt_next = count + CW'(1) - CW'(pop);
  assign room     = (cnt_next < CW'(DEPTH));
  assign wdata    = '{pc: addr_q, instr: bus.mem_rdata};

`ifdef IF_MISALIGN_TRAP_EN
  logic err_q;
  logic err_n;
  logic bad;
  assign bad = redir & bus.redirect_pc[0];
  assign tgt = bus.redirect_pc;
  assign misalign_err = err_q;
`else
  assign tgt = bus.redirect_pc & 16'hFFFE;
`endif

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = ~empty;
  assign bus.instr       = rdata.instr;
  assign bus.instr_pc    = rdata.pc;

  // Next state, next PC and the registered request outputs.
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    req_n   = req_q;
    addr_n  = addr_q;
    push    = 1'b0;
    flush   = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    err_n   = err_q | bad;
`endif
    if (redir) begin
      flush = 1'b1;
      pc_n  = tgt;
    end
    unique case (state)
      IF_IDLE: begin
        if (!redir && !full) begin
          state_n = IF_WAIT;
          req_n   = 1'b1;
          addr_n  = fetch_pc;
        end
      end
      IF_WAIT: begin
        if (redir) begin
          if (ack) begin
            req_n  = 1'b1;
            addr_n = tgt;
          end else begin
            state_n = IF_DISCARD;
          end
        end else if (ack) begin
          push = 1'b1;
          pc_n = pc_inc;
          if (room) begin
            addr_n = pc_inc;
          end else begin
            state_n = IF_IDLE;
            req_n   = 1'b0;
          end
        end
      end
      IF_DISCARD: begin
        if (ack) begin
          state_n = IF_WAIT;
          addr_n  = redir ? tgt : fetch_pc;
        end
      end
      default: begin
        state_n = IF_IDLE;
        req_n   = 1'b0;
      end
    endcase
`ifdef IF_MISALIGN_TRAP_EN
    if (err_n && state_n == IF_WAIT) begin
      state_n = IF_IDLE;
      req_n   = 1'b0;
    end
`endif
  end

  // FSM, fetch PC and request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IF_IDLE;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      req_q    <= req_n;
      addr_q   <= addr_n;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_n;
  end
`endif

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency imem model.
// Expected values are hand-computed; memory returns 16'h1000 + addr.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;

  instr_fetch_unit_if bus();

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_err;
`endif

  instr_fetch_unit #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] slow_addr = 16'hFFFF;
  logic [15:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pop_log[$];
  logic        saw_req;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.instr_ready = rdy;
    step(2);
    req_log.delete();
    req_cyc.delete();
    pop_log.delete();
    reset = 1'b1;
  endtask

  task automatic wait_req(input logic [15:0] a);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == a) found = 1'b1;
    end
    chk("wait_req", 32'(found), 32'd1);
  endtask

  function automatic int pops_at(input logic [15:0] pc);
    int c;
    c = 0;
    foreach (pop_log[i]) if (pop_log[i][31:16] == pc) c++;
    return c;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: one request at a time, ack after 1 (or 3) cycles.
  initial begin
    int          cnt;
    logic        busy;
    logic [15:0] cur;
    cnt = 0;
    busy = 1'b0;
    cur = 16'h0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy = 1'b0;
        bus.mem_ack = 1'b0;
      end else begin
        if (bus.mem_ack) bus.mem_ack = 1'b0;
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = 16'h1000 + cur;
            busy = 1'b0;
          end
        end else if (bus.mem_req) begin
          busy = 1'b1;
          cur = bus.mem_addr;
          cnt = (cur == slow_addr) ? 3 : 1;
          req_log.push_back(cur);
          req_cyc.push_back(cyc);
        end
      end
    end
  end

  // Consumer-side log of every accepted {pc, instr}.
  initial forever begin
    @(negedge clk);
    #1;
    if (reset && bus.instr_valid && bus.instr_ready)
      pop_log.push_back({bus.instr_pc, bus.instr});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    step(2);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0000);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'h0000);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'h0000);
`ifdef IF_MISALIGN_TRAP_EN
    chk("rst_err", 32'(misalign_err), 32'd0);
`endif

    // Sequential fetch, zero-wait memory, consumer always ready
    do_reset(1'b1);
    step(12);
    chk("t1_req0", 32'(req_log[0]), 32'h0000);
    chk("t1_req1", 32'(req_log[1]), 32'h0002);
    chk("t1_req2", 32'(req_log[2]), 32'h0004);
    chk("t1_req3", 32'(req_log[3]), 32'h0006);
    chk("t1_rate", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
    chk("t1_pop0", pop_log[0], 32'h0000_1000);
    chk("t1_pop1", pop_log[1], 32'h0002_1002);
    chk("t1_pop2", pop_log[2], 32'h0004_1004);

    // Back-pressure: FIFO fills after exactly DEPTH requests
    do_reset(1'b0);
    step(14);
    chk("t2_nreq", 32'(req_log.size()), 32'd4);
    chk("t2_req_low", 32'(bus.mem_req), 32'd0);
    chk("t2_valid", 32'(bus.instr_valid), 32'd1);
    chk("t2_hold_instr", 32'(bus.instr), 32'h1000);
    chk("t2_hold_pc", 32'(bus.instr_pc), 32'h0000);
    step(3);
    chk("t2_still_instr", 32'(bus.instr), 32'h1000);
    bus.instr_ready = 1'b1;
    step(8);
    chk("t2_resume", 32'(req_log[4]), 32'h0008);
    chk("t2_pop0", pop_log[0], 32'h0000_1000);
    chk("t2_pop3", pop_log[3], 32'h0006_1006);

    // Redirect while a slow request is outstanding
    do_reset(1'b1);
    slow_addr = 16'h0006;
    wait_req(16'h0006);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0040;
    step(1);
    bus.redirect_valid = 1'b0;
    chk("t3_flushed", 32'(bus.instr_valid), 32'd0);
    chk("t3_req_held", 32'(bus.mem_req), 32'd1);
    chk("t3_addr_held", 32'(bus.mem_addr), 32'h0006);
    step(8);
    slow_addr = 16'hFFFF;
    chk("t3_req_tgt", 32'(req_log[4]), 32'h0040);
    chk("t3_pop_redir_cyc", pop_log[2], 32'h0004_1004);
    chk("t3_first_after", pop_log[3], 32'h0040_1040);
    chk("t3_no_addr6", 32'(pops_at(16'h0006)), 32'd0);

    // Redirect coinciding with mem_ack
    do_reset(1'b0);
    wait_req(16'h0004);
    step(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0080;
    step(1);
    bus.redirect_valid = 1'b0;
    chk("t4_empty", 32'(bus.instr_valid), 32'd0);
    chk("t4_req", 32'(bus.mem_req), 32'd1);
    chk("t4_addr", 32'(bus.mem_addr), 32'h0080);
    bus.instr_ready = 1'b1;
    step(6);
    chk("t4_req_log", 32'(req_log[3]), 32'h0080);
    chk("t4_pop0", pop_log[0], 32'h0080_1080);

    // PC wrap at the top of the address space
    do_reset(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFC;
    step(1);
    bus.redirect_valid = 1'b0;
    step(8);
    chk("t5_req0", 32'(req_log[0]), 32'hFFFC);
    chk("t5_req1", 32'(req_log[1]), 32'hFFFE);
    chk("t5_req2", 32'(req_log[2]), 32'h0000);
    chk("t5_pop1", pop_log[1], 32'hFFFE_0FFE);
    chk("t5_pop2", pop_log[2], 32'h0000_1000);

    // Odd redirect target
    do_reset(1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0013;
    step(1);
    bus.redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    chk("t6_err", 32'(misalign_err), 32'd1);
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req) saw_req = 1'b1;
      if (i == 3) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0020;
      end
      if (i == 4) bus.redirect_valid = 1'b0;
    end
    chk("t6_no_req", 32'(saw_req), 32'd0);
    chk("t6_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_sticky", 32'(misalign_err), 32'd1);
    do_reset(1'b1);
    step(1);
    chk("t6_err_clr", 32'(misalign_err), 32'd0);
`else
    step(6);
    chk("t6_req_even", 32'(req_log[0]), 32'h0012);
    chk("t6_pop_even", pop_log[0], 32'h0012_1012);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the datapath.
- Generates the fetch PC and issues req/ack reads to a variable-latency instruction memory.
- Buffers returned 16-bit instructions in a small prefetch FIFO and presents them with their PC to decode/datapath over a valid/ready handshake.
- Branch/jump redirects from the datapath flush the FIFO and restart fetch at the target.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of 2, range 2..16.
- RESET_PC, 16'h0000, fetch address after reset.
- PC_STEP, 16'd2, byte increment between sequential instructions.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  16  read address; stable while mem_req=1 and mem_ack=0.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  returned instruction word.
- redirect_valid  in  1  one-cycle pulse from the datapath (taken beq/bne/jump).
- redirect_pc  in  16  redirect target; sampled when redirect_valid=1.
- instr_valid  out  1  FIFO head is valid.
- instr  out  16  FIFO head instruction.
- instr_pc  out  16  PC of the FIFO head instruction.
- instr_ready  in  1  consumer accepts the head when instr_valid & instr_ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, response will be kept.
  - DISCARD: request outstanding, response will be dropped.
- At most one request outstanding at any time.
- IDLE -> WAIT when free slots = DEPTH - count is >= 1 and no redirect this cycle. mem_req=1 and mem_addr=fetch_pc are registered outputs, asserted the cycle after the decision.
- WAIT:
  - On mem_ack: push {mem_rdata, mem_addr} into the FIFO and set fetch_pc += PC_STEP (16-bit wrap: 16'hFFFE -> 16'h0000).
  - Then go to WAIT with the next address if a slot is still free after the push, accounting for a same-cycle pop; otherwise go to IDLE.
  - mem_req drops in the ack cycle's successor only when moving to IDLE.
- WAIT + redirect_valid without mem_ack -> DISCARD.
- DISCARD: on mem_ack drop the data, then issue a request at the redirect target (go to WAIT).
- Redirect in any state:
  - FIFO flushed (count=0) and fetch_pc=redirect_pc on the same edge.
  - instr_valid=0 on the next cycle.
  - A pop in the redirect cycle still completes; the consumer has seen it.
- Redirect and mem_ack in the same cycle: the response is dropped and the next request goes to the target; no DISCARD is needed.
- FIFO push and pop in the same cycle when full: both occur and count is unchanged.
- Pop when empty is ignored. A push is never issued when full, by construction.
- Latency: a FIFO push becomes instr_valid on the next cycle. With zero-wait memory (ack the cycle after req), sustained throughput is 1 instruction per 2 cycles.
- instr/instr_pc are held stable while instr_valid=1 and instr_ready=0.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[0]=1 sets misalign_err sticky until reset, flushes the FIFO, and halts fetch (state forced to IDLE, no new mem_req).
  - An outstanding response still completes and is dropped.
- Not defined:
  - Port is absent.
  - redirect_pc[0] is forced to 0 and fetch continues normally.

Decomposition:
- Shared package if_pkg holds:
  - state encoding constants IF_IDLE=2'd0, IF_WAIT=2'd1, IF_DISCARD=2'd2;
  - default PC_STEP;
  - default RESET_PC.
- One sub-module, if_prefetch_fifo:
  - parameterised by DEPTH and width 32 ({pc, instr});
  - synchronous push/pop/flush, count output, async active-low reset.
- The FSM and PC logic stay in instr_fetch_unit.

Test Plan:
- Reset release, memory acks 1 cycle after req with rdata=16'h1000+addr, instr_ready=1 -> mem_addr sequence 0,2,4,6; instr/instr_pc pairs (16'h1000,0), (16'h1002,2), (16'h1004,4) in order.
- instr_ready=0 with DEPTH=4 -> exactly 4 requests issued, then mem_req=0; instr holds 16'h1000. Raise ready -> fetch resumes at addr 8.
- Redirect to 16'h0040 while WAIT on addr 6 with the ack delayed 3 cycles -> the addr-6 data never appears; next mem_addr=16'h0040; first instr_pc after redirect is 16'h0040.
- Redirect and mem_ack in the same cycle -> acked data dropped, next mem_addr=redirect_pc, FIFO empty next cycle.
- fetch_pc=16'hFFFE -> next request at 16'h0000.
- With IF_MISALIGN_TRAP_EN, redirect_pc=16'h0013 -> misalign_err=1, instr_valid=0, mem_req stays 0 until reset. Without the macro, the same stimulus gives next mem_addr=16'h0012.
